// File: rtl/ctx_restore_pkg.sv
// Shared definitions for the context-restore engine: FSM states, slot layout
// and the slot address helper.
package ctx_restore_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_PC,
        S_RD_REG,
        S_CHK,
        S_LOAD
    } state_t;

    localparam int unsigned CTX_SLOT_WORDS = 8;
    localparam int unsigned CTX_PC_OFS     = 0;
    localparam int unsigned CTX_CHK_OFS    = 7;

    function automatic logic [31:0] ctx_addr(input logic [31:0] base,
                                             input logic [31:0] slot,
                                             input logic [2:0]  ofs);
        return base + slot * 32'(CTX_SLOT_WORDS) + {29'b0, ofs};
    endfunction

endpackage

// File: rtl/ctx_restore.sv
// Context-restore engine: reads a saved PC/register context from data memory
// and replays it as register writes followed by one PC load.
// Optional checksum verification of word 7 is enabled with `define CTX_CHECKSUM_EN.
module ctx_restore
    import ctx_restore_pkg::*;
#(
    parameter int unsigned CTX_BASE = 32,
    parameter int unsigned NREGS    = 6,
    parameter int unsigned PROC_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PROC_W-1:0] proc_id,
    output logic              busy,
    output logic              done,
    output logic              ctx_err,
    output logic              memRead,
    output logic [31:0]       posicao,
    input  logic [31:0]       saidaDados,
    output logic              reg_wr_en,
    output logic [4:0]        reg_wr_addr,
    output logic [31:0]       reg_wr_data,
    output logic              pc_load,
    output logic [31:0]       pc_value
);

`ifdef CTX_CHECKSUM_EN
    localparam state_t AFTER_REGS = S_CHK;
`else
    localparam state_t AFTER_REGS = S_LOAD;
`endif

    state_t            state, state_nx;
    logic [PROC_W-1:0] slot;
    logic [2:0]        idx;
    logic [31:0]       pc_q;
    logic [2:0]        ofs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            slot  <= '0;
            idx   <= '0;
            pc_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        slot <= proc_id;
                        idx  <= 3'd1;
                    end
                end
                S_RD_PC:  pc_q <= saidaDados;
                S_RD_REG: idx  <= idx + 3'd1;
                S_LOAD:   idx  <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        done        = 1'b0;
        memRead     = 1'b0;
        ofs         = 3'(CTX_PC_OFS);
        reg_wr_en   = 1'b0;
        reg_wr_addr = '0;
        reg_wr_data = '0;
        pc_load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RD_PC;
            end
            S_RD_PC: begin
                busy     = 1'b1;
                memRead  = 1'b1;
                state_nx = (NREGS == 0) ? AFTER_REGS : S_RD_REG;
            end
            S_RD_REG: begin
                busy        = 1'b1;
                memRead     = 1'b1;
                ofs         = idx;
                reg_wr_en   = 1'b1;
                reg_wr_addr = {2'b0, idx};
                reg_wr_data = saidaDados;
                if (idx == 3'(NREGS)) state_nx = AFTER_REGS;
            end
            S_CHK: begin
                busy     = 1'b1;
                memRead  = 1'b1;
                ofs      = 3'(CTX_CHK_OFS);
                state_nx = S_LOAD;
            end
            S_LOAD: begin
                busy     = 1'b1;
                done     = 1'b1;
                pc_load  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Address bus is parked at 0 whenever no read is in flight.
    assign posicao  = memRead ? ctx_addr(32'(CTX_BASE), 32'(slot), ofs) : '0;
    assign pc_value = pc_q;

`ifdef CTX_CHECKSUM_EN
    logic [31:0] acc;
    logic        err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_RD_PC:  acc   <= saidaDados;
                S_RD_REG: acc   <= acc ^ saidaDados;
                S_CHK:    err_q <= (saidaDados != acc);
                default: ;
            endcase
        end
    end

    assign ctx_err = err_q & (state == S_LOAD);
`else
    assign ctx_err = 1'b0;
`endif

endmodule
